// File: rtl/sha256_round_driver.sv
// sha256_round_driver
//   Sequences the SHA-256 round datapath (hash_generator) for one pre-padded
//   512-bit block. It takes the block on a valid/ready handshake, expands it
//   into the message schedule through a 16-word sliding window, and forms the
//   round terms t1/t2 from the datapath's working registers. It also drives
//   start/count/w_rdy/done until the datapath reports its final add.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   msg_valid/msg_ready  block handshake; msg[511:480] = W0 ... msg[31:0] = W15
//   a,b,c,e,f,g,h        working registers from hash_generator
//   hash_rdy             hash_generator final add complete
//   hg_start             clears hash_generator
//   count                0 makes hash_generator load the IV, never 0 elsewhere
//   w_rdy                apply one round this cycle
//   t1, t2               round terms (combinational, valid while w_rdy)
//   done                 high for exactly 5 cycles to trigger the final add
//   busy                 block in flight
//   digest_valid         one-cycle pulse: hash_generator HASH is final
module sha256_round_driver #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [511:0] msg,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  input  logic [31:0]  c,
  input  logic [31:0]  e,
  input  logic [31:0]  f,
  input  logic [31:0]  g,
  input  logic [31:0]  h,
  input  logic         hash_rdy,
  output logic         hg_start,
  output logic [4:0]   count,
  output logic         w_rdy,
  output logic [31:0]  t1,
  output logic [31:0]  t2,
  output logic         done,
  output logic         busy,
  output logic         digest_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_ROUND, S_FINAL, S_WAIT, S_DONE
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state, state_nxt;
  // rnd counts rounds 0..63 in ROUND; it wraps to 0 on the last round and is
  // then reused to time the five FINAL cycles.
  logic [5:0]  rnd;
  logic [31:0] win [16];
  logic [31:0] w_next;

  assign w_next = sml_s1(win[14]) + win[9] + sml_s0(win[1]) + win[0];
  assign t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + K[rnd] + win[0];
  assign t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rnd   <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (msg_valid) begin
            rnd <= '0;
            for (int i = 0; i < 16; i++) win[i] <= msg[511 - 32*i -: 32];
          end
        end
        S_ROUND: begin
          rnd <= rnd + 6'd1;
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w_next;
        end
        S_FINAL: rnd <= rnd + 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    msg_ready    = 1'b0;
    hg_start     = 1'b0;
    count        = 5'd31;
    w_rdy        = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    digest_valid = 1'b0;
    case (state)
      S_IDLE: begin
        msg_ready = 1'b1;
        busy      = 1'b0;
        if (msg_valid) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        hg_start  = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count     = 5'd0;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        w_rdy = 1'b1;
        // Saturate rather than wrap: a wrapped 0 would reload the IV.
        count = (rnd >= 6'd30) ? 5'd31 : rnd[4:0] + 5'd1;
        if (rnd == 6'(ROUNDS - 1)) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        // The datapath's done shift register adds once per 5 consecutive
        // high edges; a sixth would repeat the final add.
        done = 1'b1;
        if (rnd == 6'd4) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (hash_rdy) state_nxt = S_DONE;
      end
      S_DONE: begin
        digest_valid = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_driver.sv
module tb_sha256_round_driver;

  logic         clk = 1'b0;
  logic         rst;
  logic         msg_valid;
  logic         msg_ready;
  logic [511:0] msg;
  logic [31:0]  ma, mb, mc, md, me, mf, mg, mh;
  logic         hash_rdy;
  logic         hg_start;
  logic [4:0]   count;
  logic         w_rdy;
  logic [31:0]  t1, t2;
  logic         done;
  logic         busy;
  logic         digest_valid;

  always #5 clk = ~clk;

  sha256_round_driver #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg(msg),
    .a(ma), .b(mb), .c(mc), .e(me), .f(mf), .g(mg), .h(mh),
    .hash_rdy(hash_rdy), .hg_start(hg_start), .count(count), .w_rdy(w_rdy),
    .t1(t1), .t2(t2), .done(done), .busy(busy), .digest_valid(digest_valid)
  );

  localparam logic [511:0] MSG_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMP = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMP =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // hash_generator model: IV load on count==0, one round per w_rdy, final add
  // when done has been high at 5 consecutive edges, hash_rdy one cycle later.
  logic [31:0] hv [8];
  logic [4:0]  dsr;
  logic [4:0]  dsr_nx;
  assign dsr_nx = {dsr[3:0], done};

  always @(posedge clk) begin
    if (hg_start) begin
      dsr      <= '0;
      hash_rdy <= 1'b0;
    end else begin
      dsr <= dsr_nx;
      if (dsr == 5'b11111) hash_rdy <= 1'b1;
      if (dsr_nx == 5'b11111) begin
        hv[0] <= hv[0] + ma; hv[1] <= hv[1] + mb; hv[2] <= hv[2] + mc; hv[3] <= hv[3] + md;
        hv[4] <= hv[4] + me; hv[5] <= hv[5] + mf; hv[6] <= hv[6] + mg; hv[7] <= hv[7] + mh;
      end
    end
    if (count == 5'd0) begin
      ma <= IV[0]; mb <= IV[1]; mc <= IV[2]; md <= IV[3];
      me <= IV[4]; mf <= IV[5]; mg <= IV[6]; mh <= IV[7];
      for (int i = 0; i < 8; i++) hv[i] <= IV[i];
    end else if (w_rdy) begin
      mh <= mg; mg <= mf; mf <= me; me <= md + t1;
      md <= mc; mc <= mb; mb <= ma; ma <= t1 + t2;
    end
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [255:0] exp_q [$];
  int n_dv = 0;
  bit trk = 0;
  int rel, wr_n, wr_first, wr_last, dn_n, dn_first, dn_last, cz_n, cz_cyc, ovl;

  // Protocol monitor and scoreboard; rel is the cycle index with the accept
  // edge as cycle 0.
  always @(negedge clk) begin
    if (rst) begin
      trk = 0;
    end else begin
      if (trk) rel++;
      if (msg_valid && msg_ready) begin
        trk = 1; rel = 0; wr_n = 0; dn_n = 0; cz_n = 0; ovl = 0;
        wr_first = -1; wr_last = -1; dn_first = -1; dn_last = -1; cz_cyc = -1;
      end else if (trk) begin
        if (count == 5'd0) begin cz_n++; cz_cyc = rel; end
        if (w_rdy) begin if (wr_n == 0) wr_first = rel; wr_last = rel; wr_n++; end
        if (done) begin if (dn_n == 0) dn_first = rel; dn_last = rel; dn_n++; end
        if (w_rdy && done) ovl++;
        if (digest_valid) begin
          chk("dv_cycle", rel, 74);
          chk("wrdy_n", wr_n, 64);
          chk("wrdy_first", wr_first, 3);
          chk("wrdy_last", wr_last, 66);
          chk("done_n", dn_n, 5);
          chk("done_first", dn_first, 67);
          chk("done_last", dn_last, 71);
          chk("cnt0_n", cz_n, 1);
          chk("cnt0_cyc", cz_cyc, 2);
          chk("overlap", ovl, 0);
          if (exp_q.size() == 0) chk("sb_empty", 1, 0);
          else chk("digest", {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]},
                   exp_q.pop_front());
          n_dv++;
          trk = 0;
        end
      end
    end
  end

  // Presents a block at a negedge; the accept edge is the following posedge.
  task automatic send(input logic [511:0] m, input logic [255:0] dig, input bit hold);
    for (int i = 0; i < 200 && !msg_ready; i++) @(negedge clk);
    chk("send_ready", msg_ready, 1);
    msg       = m;
    msg_valid = 1'b1;
    exp_q.push_back(dig);
    @(posedge clk);
    #1;
    if (!hold) msg_valid = 1'b0;
  endtask

  task automatic wait_dv(input string tag);
    int start;
    start = n_dv;
    for (int i = 0; i < 300 && n_dv == start; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, n_dv - start, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, msg_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, hg_start, 0);
    chk({tag, "_wrdy"}, w_rdy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dv"}, digest_valid, 0);
    chk({tag, "_count"}, count, 31);
  endtask

  initial begin
    rst       = 1'b1;
    msg_valid = 1'b0;
    msg       = '0;
    #12;
    chk_idle_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single "abc" block.
    send(MSG_ABC, DIG_ABC, 1'b0);
    wait_dv("abc_dv");

    // "abc" with msg_valid held high and the empty block on msg: the empty
    // block must be ignored until IDLE, then accepted right after digest_valid.
    @(negedge clk);
    send(MSG_ABC, DIG_ABC, 1'b1);
    msg = MSG_EMP;
    exp_q.push_back(DIG_EMP);
    repeat (20) @(negedge clk);
    chk("busy_ready", msg_ready, 0);
    chk("busy_busy", busy, 1);
    wait_dv("b2b_dv1");
    @(negedge clk);
    #1;
    chk("b2b_accept", msg_ready, 1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    wait_dv("b2b_dv2");

    // Reset during round 30 abandons the block.
    @(negedge clk);
    send(MSG_ABC, DIG_ABC, 1'b0);
    repeat (32) @(negedge clk);
    chk("pre_rst_wrdy", w_rdy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_rst");
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(MSG_ABC, DIG_ABC, 1'b0);
    wait_dv("post_rst_dv");

    repeat (5) @(negedge clk);
    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
